// File: rtl/conv_window_scheduler.sv
// Control for a KxK sliding-window line buffer: accepts a raster pixel stream,
// drives the buffer shift and presents each legal, stride-aligned window to the MAC.
module conv_window_scheduler #(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_SIZE    = 28,
  parameter int COL_SIZE    = 28,
  parameter int STRIDE      = 1,
  localparam int OUT_W = (ROW_SIZE - KERNEL_SIZE) / STRIDE + 1,
  localparam int OUT_H = (COL_SIZE - KERNEL_SIZE) / STRIDE + 1,
  localparam int WR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int WC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            pix_in_valid,
  output logic            pix_in_ready,
  output logic            buf_shift_en,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [WR_W-1:0] win_row,
  output logic [WC_W-1:0] win_col,
  output logic            busy,
  output logic            frame_done
);

  localparam int PR_W = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int PC_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [PR_W-1:0] LAST_ROW = PR_W'(COL_SIZE - 1);
  localparam logic [PC_W-1:0] LAST_COL = PC_W'(ROW_SIZE - 1);
  localparam logic [PR_W-1:0] KM1_ROW  = PR_W'(KERNEL_SIZE - 1);
  localparam logic [PC_W-1:0] KM1_COL  = PC_W'(KERNEL_SIZE - 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(STRIDE - 1);
  localparam logic [WR_W-1:0] OH_LAST  = WR_W'(OUT_H - 1);
  localparam logic [WC_W-1:0] OW_LAST  = WC_W'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_t;

  state_t            state_q;
  logic [PR_W-1:0]   row_q;
  logic [PC_W-1:0]   col_q;
  logic [PH_W-1:0]   rph_q, cph_q;
  logic [WR_W-1:0]   orow_q, win_row_q;
  logic [WC_W-1:0]   ocol_q, win_col_q;
  logic              win_valid_q, frame_done_q;

  logic accepting, legal, retire, col_last, row_last;

  function automatic logic [PH_W-1:0] ph_next(input logic [PH_W-1:0] ph);
    return (ph == PH_LAST) ? '0 : ph + 1'b1;
  endfunction

  // Upstream is held off while a window waits, so the buffer never shifts under it.
  assign accepting    = (state_q == PRIME) || (state_q == STREAM);
  assign pix_in_ready = accepting && !(win_valid_q && !win_ready);
  assign buf_shift_en = pix_in_valid && pix_in_ready;
  assign col_last     = (col_q == LAST_COL);
  assign row_last     = (row_q == LAST_ROW);
  assign legal        = buf_shift_en && (row_q >= KM1_ROW) && (col_q >= KM1_COL)
                        && (rph_q == '0) && (cph_q == '0);
  assign retire       = win_valid_q && win_ready;

  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      rph_q        <= '0;
      cph_q        <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (retire) win_valid_q <= 1'b0;
      if (legal) begin
        win_valid_q <= 1'b1;
        win_row_q   <= orow_q;
        win_col_q   <= ocol_q;
        if (ocol_q == OW_LAST) begin
          ocol_q <= '0;
          orow_q <= (orow_q == OH_LAST) ? '0 : orow_q + 1'b1;
        end else begin
          ocol_q <= ocol_q + 1'b1;
        end
      end

      // Phase counters hold (index - (K-1)) mod STRIDE once past the first K-1 lines/columns.
      if (buf_shift_en) begin
        if (col_last) begin
          col_q <= '0;
          cph_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
          rph_q <= (row_last || (row_q < KM1_ROW)) ? '0 : ph_next(rph_q);
        end else begin
          col_q <= col_q + 1'b1;
          cph_q <= (col_q < KM1_COL) ? '0 : ph_next(cph_q);
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= PRIME;
            row_q   <= '0;
            col_q   <= '0;
            rph_q   <= '0;
            cph_q   <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
          end
        end
        PRIME: begin
          if (buf_shift_en && (row_q == KM1_ROW) && (col_q == KM1_COL)) state_q <= STREAM;
        end
        STREAM: begin
          if (buf_shift_en && row_last && col_last) state_q <= FLUSH;
        end
        FLUSH: begin
          if (!win_valid_q || win_ready) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
Sequences the sliding-window line-buffer datapath for one convolution layer. It accepts a raster pixel stream through a valid/ready handshake and generates the shift enable for the line-buffer chain. It tracks row and column position and qualifies only legal KxK windows, which excludes row-wrap windows and applies stride. It presents each legal window to the downstream MAC with a valid/ready handshake and stalls the stream under backpressure.

Parameters:
KERNEL_SIZE, 3, window edge length K (>=2)
ROW_SIZE, 28, pixels per image row (width W, >=K)
COL_SIZE, 28, rows per image (height H, >=K)
STRIDE, 1, window step in both directions (>=1)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin one frame; sampled only in IDLE
pix_in_valid  in  1  upstream pixel valid
pix_in_ready  out  1  scheduler can accept a pixel this cycle
buf_shift_en  out  1  shift enable to the line-buffer chain; equals pix_in_valid & pix_in_ready
win_valid  out  1  line-buffer window output holds a legal window
win_ready  in  1  downstream consumed window
win_row  out  max(1,clog2(OUT_H))  output-map row of presented window
win_col  out  max(1,clog2(OUT_W))  output-map column of presented window
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Derived sizes: OUT_W = (ROW_SIZE-K)/STRIDE+1 and OUT_H = (COL_SIZE-K)/STRIDE+1, using integer division.
- Reset value of every output is 0. Reset also sets FSM=IDLE and clears the pixel row/col counters, the stride phase counters and the output row/col counters.
- Reset asserted mid-frame aborts the frame. No frame_done is produced. Stale line-buffer contents are harmless because every frame re-primes.
- FSM states:
  - IDLE: start=1 moves to PRIME and clears counters. start while not IDLE is ignored.
  - PRIME: accepts pixels until pixel (r=K-1, c=K-1) is accepted, i.e. (K-1)*W+K pixels. No windows are produced before that point. Moves to STREAM on that acceptance. Because that pixel is itself the first legal window, STREAM starts with win_valid pending.
  - STREAM: accepts pixels and generates windows. Moves to FLUSH when pixel (H-1, W-1) is accepted.
  - FLUSH: pix_in_ready=0. Stays while win_valid=1. Once win_valid=0 (always true by the next cycle if no window is pending), pulses frame_done for one cycle and goes to IDLE.
- pix_in_ready = (PRIME or STREAM) and not (win_valid and not win_ready). Upstream is stalled whenever a window is pending and not taken, which guarantees the line buffer never shifts under an unconsumed window.
- Pixel counters advance only on buf_shift_en. Column wraps W-1 -> 0 and increments the row.
- Window legality for an accepted pixel at (r,c): r>=K-1, c>=K-1, (r-K+1) mod STRIDE == 0, and (c-K+1) mod STRIDE == 0. Modulo is implemented with phase counters, with no dividers.
- Window latency: win_valid rises the cycle after the accepting edge of the legal pixel, matching the one-cycle line-buffer register. win_row/win_col are valid with it.
- win_valid falls on the edge where win_valid & win_ready. If another legal pixel is accepted on that same edge, win_valid stays 1 and win_row/win_col advance.
- win_row/win_col follow raster order over OUT_H x OUT_W. Column wraps OUT_W-1 -> 0 and increments the row.
- Exactly OUT_H*OUT_W windows are produced per frame. Trailing pixels beyond the last stride-aligned position are consumed silently.
- Simultaneous pix_in_valid=0 and win_ready=1: the pending window is retired and no shift occurs.
- win_ready is ignored while win_valid=0.

Test Plan:
- K=3, W=H=5, STRIDE=1, pix_in_valid and win_ready tied 1, 25 pixels. Required: first win_valid the cycle after pixel 12; 9 windows in total, (0,0) through (2,2) raster; frame_done 1 cycle after the last window; busy drops with it.
- Same configuration with STRIDE=2. Required: 4 windows, triggered by pixels (2,2), (2,4), (4,2) and (4,4), with win_row/win_col = (0,0), (0,1), (1,0), (1,1).
- Backpressure: win_ready held 0 for 4 cycles while window (0,1) is pending. Required: pix_in_ready=0 and buf_shift_en=0 for those cycles, win_row/win_col stable, and the stream resumes the cycle win_ready=1.
- Row wrap, W=5, STRIDE=1: pixels (3,0) and (3,1) are accepted with no win_valid; (3,2) produces window (1,0).
- reset_n pulsed low after pixel 15. Required: all outputs go to 0 immediately; a new start then yields the full 9 windows and one frame_done.
- start pulsed during STREAM is ignored, and pix_in_valid gaps (random 0s) leave window count and order unchanged.
